// File: rtl/game_pkg.sv
// Shared game constants: state encoding, screen geometry and default speed
// values used by the formation, the rate divider and the renderer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_DESCEND = 2'd2,
    ST_LANDED  = 2'd3
  } march_state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FORM_W   = 40;

  localparam int X_MIN_DEF   = 0;
  localparam int X_MAX_DEF   = SCREEN_W - FORM_W;
  localparam int X_STEP_DEF  = 2;
  localparam int Y_START_DEF = 8;
  localparam int Y_STEP_DEF  = 4;
  localparam int Y_LAND_DEF  = 100;

  localparam logic [27:0] PERIOD_INIT_DEF = 28'd12_500_000;
  localparam logic [27:0] PERIOD_DEC_DEF  = 28'd1_000_000;
  localparam logic [27:0] PERIOD_MIN_DEF  = 28'd2_000_000;

  // Saturating decrement: never goes below floor and never underflows.
  // The floor+dec sum is formed in 29 bits so it cannot wrap.
  function automatic logic [27:0] sat_dec(input logic [27:0] value,
                                          input logic [27:0] dec,
                                          input logic [27:0] floor);
    logic [28:0] limit;
    limit = {1'b0, floor} + {1'b0, dec};
    if ({1'b0, value} >= limit) return value - dec;
    else                        return floor;
  endfunction

endpackage

// File: rtl/march_period_ctrl.sv
// Holds the rate-divider reload value, shortens it on each descent with a
// floor, and flags every change or re-initialisation with a one-cycle load.
module march_period_ctrl
  import game_pkg::*;
#(
  parameter logic [27:0] PERIOD_INIT = PERIOD_INIT_DEF,
  parameter logic [27:0] PERIOD_DEC  = PERIOD_DEC_DEF,
  parameter logic [27:0] PERIOD_MIN  = PERIOD_MIN_DEF
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        init,
  input  logic        dec,
  output logic [27:0] period_value,
  output logic        period_load
);

  logic [27:0] dec_value;

  assign dec_value = sat_dec(period_value, PERIOD_DEC, PERIOD_MIN);

  // Period register; init has priority over a decrement request.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      period_value <= PERIOD_INIT;
      period_load  <= 1'b0;
    end else if (init) begin
      period_value <= PERIOD_INIT;
      period_load  <= 1'b1;
    end else if (dec) begin
      period_value <= dec_value;
      period_load  <= (dec_value != period_value);
    end else begin
      period_load  <= 1'b0;
    end
  end

endmodule

// File: rtl/formation_march.sv
// Enemy formation controller: marches the formation origin left/right one
// step per accepted tick, descends and reverses at the walls, speeds up the
// rate divider on each descent and stops once the formation has landed.
// Handshake: tick is a single-cycle enable with no back-pressure; a tick is
// accepted only on an edge where run=1 in MARCH or DESCEND, otherwise it is
// dropped. restart outranks tick on the same edge.
module formation_march
  import game_pkg::*;
#(
  parameter int          X_MIN       = X_MIN_DEF,
  parameter int          X_MAX       = X_MAX_DEF,
  parameter int          X_STEP      = X_STEP_DEF,
  parameter int          Y_START     = Y_START_DEF,
  parameter int          Y_STEP      = Y_STEP_DEF,
  parameter int          Y_LAND      = Y_LAND_DEF,
  parameter logic [27:0] PERIOD_INIT = PERIOD_INIT_DEF,
  parameter logic [27:0] PERIOD_DEC  = PERIOD_DEC_DEF,
  parameter logic [27:0] PERIOD_MIN  = PERIOD_MIN_DEF
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         tick,
  input  logic         run,
  input  logic         restart,
  output logic [7:0]   form_x,
  output logic [6:0]   form_y,
  output logic         dir,
  output logic         step_strobe,
  output logic [27:0]  period_value,
  output logic         period_load,
  output logic         landed,
  output march_state_t state
);

  logic       accept;
  logic [8:0] x_right;
  logic [8:0] x_left;
  logic       hit_right;
  logic       hit_left;
  logic [7:0] y_down;
  logic       period_init;
  logic       period_dec;

  // Step arithmetic is widened so X_MAX+X_STEP and the y add cannot wrap
  // before the comparisons.
  assign accept    = tick & run;
  assign x_right   = {1'b0, form_x} + 9'(X_STEP);
  assign x_left    = {1'b0, form_x} - 9'(X_STEP);
  assign hit_right = (x_right > 9'(X_MAX));
  assign hit_left  = ({1'b0, form_x} < (9'(X_MIN) + 9'(X_STEP)));
  assign y_down    = {1'b0, form_y} + 8'(Y_STEP);

  assign period_init = restart | ((state == ST_IDLE) & run);
  assign period_dec  = ~restart & (state == ST_DESCEND) & accept;

  // Formation FSM with registered position, direction, strobe and landed.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= ST_IDLE;
      form_x      <= 8'(X_MIN);
      form_y      <= 7'(Y_START);
      dir         <= 1'b1;
      step_strobe <= 1'b0;
      landed      <= 1'b0;
    end else if (restart) begin
      state       <= ST_IDLE;
      form_x      <= 8'(X_MIN);
      form_y      <= 7'(Y_START);
      dir         <= 1'b1;
      step_strobe <= 1'b0;
      landed      <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_MARCH;
        end
        ST_MARCH: begin
          if (accept) begin
            if (dir) begin
              if (hit_right) begin
                state <= ST_DESCEND;
              end else begin
                form_x      <= x_right[7:0];
                step_strobe <= 1'b1;
              end
            end else begin
              if (hit_left) begin
                state <= ST_DESCEND;
              end else begin
                form_x      <= x_left[7:0];
                step_strobe <= 1'b1;
              end
            end
          end
        end
        ST_DESCEND: begin
          if (accept) begin
            form_y      <= y_down[6:0];
            dir         <= ~dir;
            step_strobe <= 1'b1;
            if (y_down >= 8'(Y_LAND)) begin
              state  <= ST_LANDED;
              landed <= 1'b1;
            end else begin
              state  <= ST_MARCH;
            end
          end
        end
        ST_LANDED: begin
          landed <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  march_period_ctrl #(
    .PERIOD_INIT (PERIOD_INIT),
    .PERIOD_DEC  (PERIOD_DEC),
    .PERIOD_MIN  (PERIOD_MIN)
  ) u_period (
    .clock        (clock),
    .clear        (clear),
    .init         (period_init),
    .dec          (period_dec),
    .period_value (period_value),
    .period_load  (period_load)
  );

endmodule

// File: tb/tb_formation_march.sv
// Bench for formation_march: directed stimulus, a behavioural model of the
// march rules checked every cycle, and literal checkpoints along the way.
module tb_formation_march;
  import game_pkg::*;

  localparam int P_INIT = 12_500_000;
  localparam int P_DEC  = 1_000_000;
  localparam int P_MIN  = 2_000_000;

  logic         clk;
  logic         clear;
  logic         tick;
  logic         run;
  logic         restart;
  logic [7:0]   form_x;
  logic [6:0]   form_y;
  logic         dir;
  logic         step_strobe;
  logic [27:0]  period_value;
  logic         period_load;
  logic         landed;
  march_state_t state;

  int tests;
  int failed;
  bit cmp_en;

  // Model of the formation, kept as plain integers and flags
  int m_x, m_y, m_dir, m_period, m_strobe, m_load;
  bit m_active, m_pend, m_landed;

  formation_march dut (
    .clock        (clk),
    .clear        (clear),
    .tick         (tick),
    .run          (run),
    .restart      (restart),
    .form_x       (form_x),
    .form_y       (form_y),
    .dir          (dir),
    .step_strobe  (step_strobe),
    .period_value (period_value),
    .period_load  (period_load),
    .landed       (landed),
    .state        (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start(input int load);
    m_x = 0; m_y = 8; m_dir = 1; m_period = P_INIT;
    m_strobe = 0; m_load = load;
    m_active = 0; m_pend = 0; m_landed = 0;
  endtask

  // Model update from the rules: one move per accepted tick
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      model_start(0);
    end else if (restart) begin
      model_start(1);
    end else begin
      m_strobe = 0;
      m_load   = 0;
      if (!m_active) begin
        if (run) begin
          m_active = 1;
          m_load   = 1;
        end
      end else if (!m_landed && run && tick) begin
        if (m_pend) begin
          int np;
          m_y    = m_y + 4;
          m_dir  = 1 - m_dir;
          m_strobe = 1;
          np = m_period - P_DEC;
          if (np < P_MIN) np = P_MIN;
          m_load   = (np != m_period);
          m_period = np;
          m_pend   = 0;
          if (m_y >= 100) m_landed = 1;
        end else if (m_dir == 1) begin
          if (m_x + 2 > 120) m_pend = 1;
          else begin m_x = m_x + 2; m_strobe = 1; end
        end else begin
          if (m_x < 2) m_pend = 1;
          else begin m_x = m_x - 2; m_strobe = 1; end
        end
      end
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      int exp_state;
      exp_state = m_landed ? 3 : (m_pend ? 2 : (m_active ? 1 : 0));
      check("cyc_form_x", form_x, m_x);
      check("cyc_form_y", form_y, m_y);
      check("cyc_dir", dir, m_dir);
      check("cyc_strobe", step_strobe, m_strobe);
      check("cyc_period", period_value, m_period);
      check("cyc_load", period_load, m_load);
      check("cyc_landed", landed, m_landed);
      check("cyc_state", state, exp_state);
    end
  end

  // Driver tasks
  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic advance_until_pend();
    for (int i = 0; i < 200 && !m_pend; i++) do_tick();
    check("reach_descend", state, ST_DESCEND);
  endtask

  task automatic descend();
    advance_until_pend();
    do_tick();
  endtask

  initial begin
    tests = 0; failed = 0; cmp_en = 0;
    tick = 0; run = 0; restart = 0;
    clear = 1'b1;
    #1 clear = 1'b0;
    cmp_en = 1;
    repeat (3) @(negedge clk);
    check("rst_form_x", form_x, 0);
    check("rst_form_y", form_y, 8);
    check("rst_dir", dir, 1);
    check("rst_period", period_value, 28'd12_500_000);
    check("rst_load", period_load, 0);
    check("rst_landed", landed, 0);
    check("rst_state", state, ST_IDLE);
    clear = 1'b1;

    // Start marching: load pulse on IDLE->MARCH, then five steps
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("start_load", period_load, 1);
    check("start_period", period_value, 28'd12_500_000);
    check("start_state", state, ST_MARCH);
    for (int i = 1; i <= 5; i++) begin
      do_tick();
      check("march_x", form_x, 2 * i);
      check("march_strobe", step_strobe, 1);
      check("march_y", form_y, 8);
    end

    // Right wall: one tick to enter DESCEND, one to descend
    for (int i = 0; i < 100 && m_x < 120; i++) do_tick();
    check("wall_x", form_x, 120);
    do_tick();
    check("wall_state", state, ST_DESCEND);
    check("wall_x_hold", form_x, 120);
    check("wall_no_strobe", step_strobe, 0);
    do_tick();
    check("desc1_y", form_y, 12);
    check("desc1_dir", dir, 0);
    check("desc1_period", period_value, 28'd11_500_000);
    check("desc1_load", period_load, 1);
    check("desc1_strobe", step_strobe, 1);

    // Second descent at left wall, then pause at x=40 going right
    descend();
    check("desc2_y", form_y, 16);
    check("desc2_dir", dir, 1);
    for (int i = 0; i < 100 && m_x < 40; i++) do_tick();
    @(negedge clk);
    run = 1'b0;
    repeat (10) do_tick();
    check("pause_x", form_x, 40);
    @(negedge clk);
    run = 1'b1;
    do_tick();
    check("resume_x", form_x, 42);

    // Descend until the period floor is reached
    for (int i = 0; i < 30 && m_period != P_MIN; i++) descend();
    check("floor_period", period_value, 28'd2_000_000);
    check("floor_load", period_load, 1);
    descend();
    check("floor_hold_period", period_value, 28'd2_000_000);
    check("floor_no_load", period_load, 0);
    check("floor_strobe", step_strobe, 1);

    // Descend until landed; further ticks do nothing
    for (int i = 0; i < 30 && !m_landed; i++) descend();
    check("land_flag", landed, 1);
    check("land_y", form_y, 100);
    check("land_state", state, ST_LANDED);
    repeat (4) do_tick();
    check("land_hold_y", form_y, 100);
    check("land_hold_strobe", step_strobe, 0);

    // Restart coinciding with tick: restart wins
    @(negedge clk);
    restart = 1'b1;
    tick    = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    tick    = 1'b0;
    check("restart_x", form_x, 0);
    check("restart_y", form_y, 8);
    check("restart_landed", landed, 0);
    check("restart_load", period_load, 1);
    check("restart_period", period_value, 28'd12_500_000);
    check("restart_state", state, ST_IDLE);

    // March a few steps, then restart+tick mid-march
    repeat (3) do_tick();
    check("remarch_x", form_x, 6);
    @(negedge clk);
    restart = 1'b1;
    tick    = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    tick    = 1'b0;
    check("restart_tick_x", form_x, 0);
    check("restart_tick_strobe", step_strobe, 0);

    // Async clear between edges while in DESCEND
    advance_until_pend();
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    check("aclr_state", state, ST_IDLE);
    check("aclr_x", form_x, 0);
    check("aclr_y", form_y, 8);
    check("aclr_dir", dir, 1);
    check("aclr_period", period_value, 28'd12_500_000);
    check("aclr_load", period_load, 0);
    check("aclr_strobe", step_strobe, 0);
    @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
